// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port word memory between two bus masters.
//   Port 0 is the processor, port 1 a loader/DMA master. One access is granted
//   per cycle; a losing strobe is parked in that port's pending registers and
//   served later while the port's busy flag is raised. Uncontended requests go
//   straight through to the memory in the same cycle.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   pN_addr/rstrb/wmask/wdata  request from port N (strobe = rstrb | wmask!=0)
//   pN_rdata              read data for port N's last completed read
//   pN_busy               port N's request has not yet been served
//   mem_addr/rstrb/wmask/wdata  request to the memory
//   mem_rdata             memory read data, valid the cycle after mem_rstrb
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN  defined   -> round-robin tie breaking
//                           undefined -> fixed priority, port 0 wins ties
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] p0_addr,
  input  logic        p0_rstrb,
  input  logic [3:0]  p0_wmask,
  input  logic [31:0] p0_wdata,
  output logic [31:0] p0_rdata,
  output logic        p0_busy,
  input  logic [31:0] p1_addr,
  input  logic        p1_rstrb,
  input  logic [3:0]  p1_wmask,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p1_rdata,
  output logic        p1_busy,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rd;
  } req_t;

  // State
  logic   pend0, pend1;
  req_t   pq0, pq1;
  owner_t rd_owner;
  logic [31:0] hold0, hold1;

  // Next state
  logic   pend0_n, pend1_n;
  req_t   pq0_n, pq1_n;
  owner_t rd_owner_n;
  logic [31:0] hold0_n, hold1_n;

  // Request decode
  logic strobe0, strobe1;
  logic new0, new1;
  logic cand0, cand1;
  logic grant0, grant1;
  req_t live0, live1;
  req_t req0, req1;

  assign strobe0 = p0_rstrb | (p0_wmask != 4'd0);
  assign strobe1 = p1_rstrb | (p1_wmask != 4'd0);

  // A strobe while a request is already outstanding is ignored.
  assign new0  = strobe0 & ~pend0;
  assign new1  = strobe1 & ~pend1;
  assign cand0 = pend0 | new0;
  assign cand1 = pend1 | new1;

  // Write wins when rstrb and wmask are both asserted.
  assign live0 = '{addr: p0_addr, wdata: p0_wdata, wmask: p0_wmask,
                   rd: (p0_wmask == 4'd0)};
  assign live1 = '{addr: p1_addr, wdata: p1_wdata, wmask: p1_wmask,
                   rd: (p1_wmask == 4'd0)};

  assign req0 = pend0 ? pq0 : live0;
  assign req1 = pend1 ? pq1 : live1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant;    // 1: port 1 was granted most recently
  logic last_grant_n;

  assign grant0 = ~reset & cand0 & (~cand1 | last_grant);
  assign grant1 = ~reset & cand1 & (~cand0 | ~last_grant);

  always_comb begin
    last_grant_n = last_grant;
    if (grant1)      last_grant_n = 1'b1;
    else if (grant0) last_grant_n = 1'b0;
  end

  // Reset to "port 1 last" so port 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant <= 1'b1;
    else       last_grant <= last_grant_n;
  end
`else
  assign grant0 = ~reset & cand0;
  assign grant1 = ~reset & cand1 & ~cand0;
`endif

  // Memory-side mux; idle cycles drive all zeros.
  always_comb begin
    mem_addr  = '0;
    mem_rstrb = 1'b0;
    mem_wmask = '0;
    mem_wdata = '0;
    if (grant0) begin
      mem_addr  = req0.addr;
      mem_rstrb = req0.rd;
      mem_wmask = req0.wmask;
      mem_wdata = req0.wdata;
    end else if (grant1) begin
      mem_addr  = req1.addr;
      mem_rstrb = req1.rd;
      mem_wmask = req1.wmask;
      mem_wdata = req1.wdata;
    end
  end

  assign p0_busy = ~reset & (pend0 | (strobe0 & ~grant0));
  assign p1_busy = ~reset & (pend1 | (strobe1 & ~grant1));

  assign p0_rdata = reset ? '0 : ((rd_owner == OWN_P0) ? mem_rdata : hold0);
  assign p1_rdata = reset ? '0 : ((rd_owner == OWN_P1) ? mem_rdata : hold1);

  always_comb begin
    pend0_n    = pend0;
    pend1_n    = pend1;
    pq0_n      = pq0;
    pq1_n      = pq1;
    rd_owner_n = rd_owner;
    hold0_n    = hold0;
    hold1_n    = hold1;

    if (grant0)     pend0_n = 1'b0;
    else if (new0) begin
      pend0_n = 1'b1;
      pq0_n   = live0;
    end

    if (grant1)     pend1_n = 1'b0;
    else if (new1) begin
      pend1_n = 1'b1;
      pq1_n   = live1;
    end

    // Only reads move ownership; writes leave rd_owner and holds alone.
    if (grant0 && req0.rd)      rd_owner_n = OWN_P0;
    else if (grant1 && req1.rd) rd_owner_n = OWN_P1;

    if (rd_owner == OWN_P0) hold0_n = mem_rdata;
    if (rd_owner == OWN_P1) hold1_n = mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend0    <= 1'b0;
      pend1    <= 1'b0;
      pq0      <= '0;
      pq1      <= '0;
      rd_owner <= OWN_NONE;
      hold0    <= '0;
      hold1    <= '0;
    end else begin
      pend0    <= pend0_n;
      pend1    <= pend1_n;
      pq0      <= pq0_n;
      pq1      <= pq1_n;
      rd_owner <= rd_owner_n;
      hold0    <= hold0_n;
      hold1    <= hold1_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector bench for mem_arbiter with a small word
// memory model (write bytes on wmask, register read data on rstrb only).
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p0_rstrb, p0_busy;
  logic [3:0]  p0_wmask;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        p1_rstrb, p1_busy;
  logic [3:0]  p1_wmask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:63];
  logic        load_en;
  logic [5:0]  load_idx;
  logic [31:0] load_data;
  int          p1_wr_count;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_addr(p0_addr), .p0_rstrb(p0_rstrb), .p0_wmask(p0_wmask),
    .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_busy(p0_busy),
    .p1_addr(p1_addr), .p1_rstrb(p1_rstrb), .p1_wmask(p1_wmask),
    .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_busy(p1_busy),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_data;
    if (mem_wmask[0]) mem[mem_addr[7:2]][7:0]   <= mem_wdata[7:0];
    if (mem_wmask[1]) mem[mem_addr[7:2]][15:8]  <= mem_wdata[15:8];
    if (mem_wmask[2]) mem[mem_addr[7:2]][23:16] <= mem_wdata[23:16];
    if (mem_wmask[3]) mem[mem_addr[7:2]][31:24] <= mem_wdata[31:24];
    if (mem_rstrb) mem_rdata <= mem[mem_addr[7:2]];
  end

  always @(posedge clk) begin
    if (reset) p1_wr_count <= 0;
    else if (mem_wmask != 4'd0 && mem_addr == 32'h80) p1_wr_count <= p1_wr_count + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    p0_addr = '0; p0_rstrb = 1'b0; p0_wmask = '0; p0_wdata = '0;
    p1_addr = '0; p1_rstrb = 1'b0; p1_wmask = '0; p1_wdata = '0;
  endtask

  task automatic load_word(input logic [5:0] idx, input logic [31:0] data);
    load_en = 1'b1; load_idx = idx; load_data = data;
    step();
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load_word(6'd4,  32'hDEADBEEF);
    load_word(6'd8,  32'hCAFEF00D);
    load_word(6'd16, 32'hA5A5A5A5);
    load_word(6'd32, 32'h00000000);
    p0_addr = 32'h10; p0_rstrb = 1'b1;
    p1_addr = 32'h40; p1_wmask = 4'hF; p1_wdata = 32'hFFFFFFFF;
    #1;
    vectors++; if (p0_busy !== 1'b0) begin miscompares++; $display("FAIL rst_p0_busy: got %h want 0", p0_busy); end
    vectors++; if (p1_busy !== 1'b0) begin miscompares++; $display("FAIL rst_p1_busy: got %h want 0", p1_busy); end
    vectors++; if (mem_rstrb !== 1'b0) begin miscompares++; $display("FAIL rst_mem_rstrb: got %h want 0", mem_rstrb); end
    vectors++; if (mem_wmask !== 4'h0) begin miscompares++; $display("FAIL rst_mem_wmask: got %h want 0", mem_wmask); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    vectors++; if (p0_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_p0_rdata: got %h want 0", p0_rdata); end
    vectors++; if (p1_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_p1_rdata: got %h want 0", p1_rdata); end
    clear_inputs();
    step();
    reset = 1'b0;
    #1;
    vectors++; if (p0_rdata !== 32'h0) begin miscompares++; $display("FAIL rel_p0_rdata: got %h want 0", p0_rdata); end
    vectors++; if (mem[16] !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL rst_no_write: got %h want a5a5a5a5", mem[16]); end
  endtask

  task automatic test_solo_read();
    step();
    p0_addr = 32'h10; p0_rstrb = 1'b1;
    #1;
    vectors++; if (mem_rstrb !== 1'b1) begin miscompares++; $display("FAIL solo_rstrb: got %h want 1", mem_rstrb); end
    vectors++; if (mem_addr !== 32'h10) begin miscompares++; $display("FAIL solo_addr: got %h want 10", mem_addr); end
    vectors++; if (p0_busy !== 1'b0) begin miscompares++; $display("FAIL solo_busy: got %h want 0", p0_busy); end
    step();
    clear_inputs();
    #1;
    vectors++; if (p0_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL solo_rdata: got %h want deadbeef", p0_rdata); end
    vectors++; if (p1_rdata !== 32'h0) begin miscompares++; $display("FAIL solo_p1_rdata: got %h want 0", p1_rdata); end
    vectors++; if (mem_rstrb !== 1'b0 || mem_addr !== 32'h0) begin miscompares++; $display("FAIL idle_mem: got rstrb %h addr %h want 0 0", mem_rstrb, mem_addr); end
  endtask

  task automatic p1_solo_read();
    step();
    p1_addr = 32'h20; p1_rstrb = 1'b1;
    step();
    clear_inputs();
  endtask

`ifdef MEM_ARB_ROUND_ROBIN_EN
  task automatic test_tie();
    p1_solo_read();
    step();
    p0_addr = 32'h10; p0_rstrb = 1'b1;
    p1_addr = 32'h20; p1_rstrb = 1'b1;
    #1;
    vectors++; if (mem_addr !== 32'h10) begin miscompares++; $display("FAIL tie_T_addr: got %h want 10", mem_addr); end
    vectors++; if (p1_busy !== 1'b1) begin miscompares++; $display("FAIL tie_T_p1_busy: got %h want 1", p1_busy); end
    vectors++; if (p0_busy !== 1'b0) begin miscompares++; $display("FAIL tie_T_p0_busy: got %h want 0", p0_busy); end
    step();
    clear_inputs();
    #1;
    vectors++; if (mem_addr !== 32'h20 || mem_rstrb !== 1'b1) begin miscompares++; $display("FAIL tie_T1_mem: got addr %h rstrb %h want 20 1", mem_addr, mem_rstrb); end
    vectors++; if (p1_busy !== 1'b1) begin miscompares++; $display("FAIL tie_T1_p1_busy: got %h want 1", p1_busy); end
    vectors++; if (p0_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL tie_T1_p0_rdata: got %h want deadbeef", p0_rdata); end
    step();
    #1;
    vectors++; if (p1_busy !== 1'b0) begin miscompares++; $display("FAIL tie_T2_p1_busy: got %h want 0", p1_busy); end
    vectors++; if (p1_rdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL tie_T2_p1_rdata: got %h want cafef00d", p1_rdata); end
    vectors++; if (p0_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL tie_T2_p0_rdata: got %h want deadbeef", p0_rdata); end
  endtask
`else
  task automatic test_tie();
    step();
    p0_addr = 32'h10; p0_rstrb = 1'b1;
    p1_addr = 32'h20; p1_rstrb = 1'b1;
    #1;
    vectors++; if (mem_addr !== 32'h10) begin miscompares++; $display("FAIL fix_A_addr: got %h want 10", mem_addr); end
    vectors++; if (p1_busy !== 1'b1) begin miscompares++; $display("FAIL fix_A_p1_busy: got %h want 1", p1_busy); end
    step();
    clear_inputs();
    #1;
    vectors++; if (mem_addr !== 32'h20 || mem_rstrb !== 1'b1) begin miscompares++; $display("FAIL fix_A1_mem: got addr %h rstrb %h want 20 1", mem_addr, mem_rstrb); end
    vectors++; if (p1_busy !== 1'b1) begin miscompares++; $display("FAIL fix_A1_p1_busy: got %h want 1", p1_busy); end
    step();
    p0_addr = 32'h10; p0_rstrb = 1'b1;
    p1_addr = 32'h20; p1_rstrb = 1'b1;
    #1;
    vectors++; if (mem_addr !== 32'h10) begin miscompares++; $display("FAIL fix_A2_addr: got %h want 10", mem_addr); end
    vectors++; if (p1_busy !== 1'b1) begin miscompares++; $display("FAIL fix_A2_p1_busy: got %h want 1", p1_busy); end
    vectors++; if (p1_rdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL fix_A2_p1_rdata: got %h want cafef00d", p1_rdata); end
    step();
    clear_inputs();
    #1;
    vectors++; if (mem_addr !== 32'h20) begin miscompares++; $display("FAIL fix_A3_addr: got %h want 20", mem_addr); end
    vectors++; if (p0_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL fix_A3_p0_rdata: got %h want deadbeef", p0_rdata); end
    step();
    #1;
    vectors++; if (p1_busy !== 1'b0) begin miscompares++; $display("FAIL fix_A4_p1_busy: got %h want 0", p1_busy); end
    vectors++; if (p1_rdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL fix_A4_p1_rdata: got %h want cafef00d", p1_rdata); end
  endtask
`endif

  task automatic test_write();
    step();
    p0_addr = 32'h40; p0_rstrb = 1'b1;
    p1_addr = 32'h40; p1_wmask = 4'b0011; p1_wdata = 32'h12345678;
    #1;
    vectors++; if (mem_rstrb !== 1'b1 || mem_wmask !== 4'h0) begin miscompares++; $display("FAIL wr_W_mem: got rstrb %h wmask %h want 1 0", mem_rstrb, mem_wmask); end
    vectors++; if (p1_busy !== 1'b1) begin miscompares++; $display("FAIL wr_W_p1_busy: got %h want 1", p1_busy); end
    step();
    clear_inputs();
    #1;
    vectors++; if (mem_wmask !== 4'b0011 || mem_wdata !== 32'h12345678) begin miscompares++; $display("FAIL wr_W1_mem: got wmask %h wdata %h want 3 12345678", mem_wmask, mem_wdata); end
    vectors++; if (mem_addr !== 32'h40 || mem_rstrb !== 1'b0) begin miscompares++; $display("FAIL wr_W1_addr: got addr %h rstrb %h want 40 0", mem_addr, mem_rstrb); end
    vectors++; if (p0_rdata !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL wr_W1_p0_rdata: got %h want a5a5a5a5", p0_rdata); end
    vectors++; if (p1_busy !== 1'b1) begin miscompares++; $display("FAIL wr_W1_p1_busy: got %h want 1", p1_busy); end
    step();
    p0_addr = 32'h40; p0_rstrb = 1'b1;
    #1;
    vectors++; if (p1_busy !== 1'b0) begin miscompares++; $display("FAIL wr_W2_p1_busy: got %h want 0", p1_busy); end
    vectors++; if (p0_rdata !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL wr_W2_p0_rdata: got %h want a5a5a5a5", p0_rdata); end
    step();
    clear_inputs();
    #1;
    vectors++; if (p0_rdata !== 32'hA5A55678) begin miscompares++; $display("FAIL wr_readback: got %h want a5a55678", p0_rdata); end
    vectors++; if (p1_rdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL wr_p1_rdata: got %h want cafef00d", p1_rdata); end
  endtask

  task automatic test_protocol();
    p1_solo_read();
    step();
    p0_addr = 32'h10; p0_rstrb = 1'b1;
    p1_addr = 32'h80; p1_wmask = 4'hF; p1_wdata = 32'h11111111;
    #1;
    vectors++; if (p1_busy !== 1'b1 || mem_addr !== 32'h10) begin miscompares++; $display("FAIL prot_V: got busy %h addr %h want 1 10", p1_busy, mem_addr); end
    step();
    p0_addr = '0; p0_rstrb = 1'b0;
    p1_wdata = 32'h22222222;
    #1;
    vectors++; if (mem_wdata !== 32'h11111111 || mem_wmask !== 4'hF) begin miscompares++; $display("FAIL prot_V1_mem: got wdata %h wmask %h want 11111111 f", mem_wdata, mem_wmask); end
    vectors++; if (p1_busy !== 1'b1) begin miscompares++; $display("FAIL prot_V1_busy: got %h want 1", p1_busy); end
    step();
    clear_inputs();
    #1;
    vectors++; if (p1_busy !== 1'b0 || mem_wmask !== 4'h0) begin miscompares++; $display("FAIL prot_V2: got busy %h wmask %h want 0 0", p1_busy, mem_wmask); end
    step();
    #1;
    vectors++; if (p1_wr_count !== 1) begin miscompares++; $display("FAIL prot_count: got %0d want 1", p1_wr_count); end
    vectors++; if (mem[32] !== 32'h11111111) begin miscompares++; $display("FAIL prot_word: got %h want 11111111", mem[32]); end
  endtask

  task automatic test_reset_midflight();
    step();
    p0_addr = 32'h10; p0_rstrb = 1'b1;
    p1_addr = 32'h40; p1_wmask = 4'hF; p1_wdata = 32'hFFFFFFFF;
    #1;
    vectors++; if (p1_busy !== 1'b1 || mem_rstrb !== 1'b1) begin miscompares++; $display("FAIL mid_R: got busy %h rstrb %h want 1 1", p1_busy, mem_rstrb); end
    step();
    clear_inputs();
    reset = 1'b1;
    #1;
    vectors++; if (mem_wmask !== 4'h0 || mem_addr !== 32'h0) begin miscompares++; $display("FAIL mid_rst_mem: got wmask %h addr %h want 0 0", mem_wmask, mem_addr); end
    vectors++; if (p1_busy !== 1'b0 || p0_busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy: got p0 %h p1 %h want 0 0", p0_busy, p1_busy); end
    vectors++; if (p0_rdata !== 32'h0) begin miscompares++; $display("FAIL mid_rst_rdata: got %h want 0", p0_rdata); end
    step();
    reset = 1'b0;
    #1;
    vectors++; if (mem[16] !== 32'hA5A55678) begin miscompares++; $display("FAIL mid_word: got %h want a5a55678", mem[16]); end
    step();
    p0_addr = 32'h10; p0_rstrb = 1'b1;
    p1_addr = 32'h20; p1_rstrb = 1'b1;
    #1;
    vectors++; if (mem_addr !== 32'h10 || p0_busy !== 1'b0) begin miscompares++; $display("FAIL mid_tie_addr: got addr %h p0_busy %h want 10 0", mem_addr, p0_busy); end
    vectors++; if (p1_busy !== 1'b1) begin miscompares++; $display("FAIL mid_tie_p1_busy: got %h want 1", p1_busy); end
    step();
    clear_inputs();
    #1;
    vectors++; if (mem_addr !== 32'h20 || p0_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL mid_tie_T1: got addr %h rdata %h want 20 deadbeef", mem_addr, p0_rdata); end
    step();
    #1;
    vectors++; if (p1_rdata !== 32'hCAFEF00D || p1_busy !== 1'b0) begin miscompares++; $display("FAIL mid_tie_T2: got rdata %h busy %h want cafef00d 0", p1_rdata, p1_busy); end
  endtask

  initial begin
    reset = 1'b1;
    load_en = 1'b0; load_idx = '0; load_data = '0;
    clear_inputs();
    test_reset();
    test_solo_read();
    test_tie();
    test_write();
    test_protocol();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
